// File: rtl/axi_full_pkg.sv
// Shared FSM encodings and AXI response codes for the AXI full slave memory.
package axi_full_pkg;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic R_IDLE = 1'b0;
  localparam logic R_DATA = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [1:0] resp_of(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_full_s_ram.sv
// Word-wide storage: byte-enabled synchronous write port, combinational read port.
module axi_full_s_ram
  import axi_full_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IW     = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic [IW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Contents survive reset, so this array has no reset branch.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wstrb_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_full_s_module.sv
// AXI4 full slave backed by an on-chip RAM; INCR bursts, independent read/write FSMs.
// Optional AXI_FULL_S_ERRRESP_EN: out-of-window bursts return SLVERR and do not touch memory.
module axi_full_s_module
  import axi_full_pkg::*;
#(
  parameter logic [31:0] C_S_TARGET_SLAVE_BASE_ADDR = 32'h80000000,
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_MEM_DEPTH      = 256
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int IDW   = C_S_AXI_ID_WIDTH;
  localparam int BYTES = DW / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int IW    = $clog2(C_S_MEM_DEPTH);
  localparam logic [AW-1:0] BASE = AW'(C_S_TARGET_SLAVE_BASE_ADDR);

  function automatic logic [IW-1:0] word_idx(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - BASE;
    return IW'(off >> BSH);
  endfunction

  logic aw_err_s, ar_err_s;
`ifdef AXI_FULL_S_ERRRESP_EN
  localparam int EW   = AW + 10;
  localparam int SPAN = C_S_MEM_DEPTH * BYTES;

  // Underflow of the base is caught by the compare; the end offset is widened so it cannot wrap.
  function automatic logic out_of_range(input logic [AW-1:0] a, input logic [7:0] len);
    logic [EW-1:0] end_off;
    end_off = EW'(a - BASE) + (EW'(len) << BSH) + EW'(BYTES - 1);
    return (a < BASE) || (end_off >= EW'(SPAN));
  endfunction

  assign aw_err_s = out_of_range(S_AXI_AWADDR, S_AXI_AWLEN);
  assign ar_err_s = out_of_range(S_AXI_ARADDR, S_AXI_ARLEN);
`else
  assign aw_err_s = 1'b0;
  assign ar_err_s = 1'b0;
`endif

  logic [1:0]     w_state_q, w_state_d;
  logic [IW-1:0]  w_idx_q, w_idx_d;
  logic [7:0]     w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [IDW-1:0] w_id_q, w_id_d;
  logic           w_err_q, w_err_d;
  logic           awready_q, wready_q, bvalid_q;
  logic           aw_hs_s, w_hs_s, b_hs_s;

  logic           r_state_q, r_state_d;
  logic [IW-1:0]  r_idx_q, r_idx_d;
  logic [7:0]     r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [IDW-1:0] r_id_q, r_id_d;
  logic           r_err_q, r_err_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           rlast_q, rlast_d, rvalid_q, rvalid_d, arready_q;
  logic           ar_hs_s, r_hs_s;

  logic [IW-1:0]  ram_raddr_s;
  logic [DW-1:0]  ram_rdata_s;
  logic           ram_we_s;
  logic           unused_s;

  // The beat counter alone closes a write burst; WLAST carries no information here.
  assign unused_s = S_AXI_WLAST;

  assign aw_hs_s  = S_AXI_AWVALID & awready_q;
  assign w_hs_s   = S_AXI_WVALID & wready_q;
  assign b_hs_s   = bvalid_q & S_AXI_BREADY;
  assign ar_hs_s  = S_AXI_ARVALID & arready_q;
  assign r_hs_s   = rvalid_q & S_AXI_RREADY;
  assign ram_we_s = w_hs_s & ~w_err_q;

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_id_d    = w_id_q;
    w_err_d   = w_err_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_s) begin
          w_idx_d   = word_idx(S_AXI_AWADDR);
          w_len_d   = S_AXI_AWLEN;
          w_cnt_d   = 8'd0;
          w_id_d    = S_AXI_AWID;
          w_err_d   = aw_err_s;
          w_state_d = W_DATA;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_DATA: begin
        if (w_hs_s) begin
          w_idx_d = w_idx_q + IW'(1);
          w_cnt_d = w_cnt_q + 8'd1;
          if (w_cnt_q == w_len_q) begin
            w_state_d = W_RESP;
          end else begin
            w_state_d = W_DATA;
          end
        end else begin
          w_state_d = W_DATA;
        end
      end
      W_RESP: begin
        if (b_hs_s) begin
          w_state_d = W_IDLE;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_len_q   <= 8'd0;
      w_cnt_q   <= 8'd0;
      w_id_q    <= '0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_id_q    <= w_id_d;
      w_err_q   <= w_err_d;
      awready_q <= (w_state_d == W_IDLE);
      wready_q  <= (w_state_d == W_DATA);
      bvalid_q  <= (w_state_d == W_RESP);
    end
  end

  // Read data is captured one beat ahead and only advances on a handshake, so stalls hold it.
  always_comb begin
    r_state_d   = r_state_q;
    r_idx_d     = r_idx_q;
    r_len_d     = r_len_q;
    r_cnt_d     = r_cnt_q;
    r_id_d      = r_id_q;
    r_err_d     = r_err_q;
    rdata_d     = rdata_q;
    rlast_d     = rlast_q;
    rvalid_d    = rvalid_q;
    ram_raddr_s = r_idx_q + IW'(1);
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_idx_d     = word_idx(S_AXI_ARADDR);
          ram_raddr_s = word_idx(S_AXI_ARADDR);
          r_len_d     = S_AXI_ARLEN;
          r_cnt_d     = 8'd0;
          r_id_d      = S_AXI_ARID;
          r_err_d     = ar_err_s;
          rdata_d     = ar_err_s ? '0 : ram_rdata_s;
          rlast_d     = (S_AXI_ARLEN == 8'd0);
          rvalid_d    = 1'b1;
          r_state_d   = R_DATA;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (r_hs_s && rlast_q) begin
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          r_state_d = R_IDLE;
        end else if (r_hs_s) begin
          r_idx_d = r_idx_q + IW'(1);
          r_cnt_d = r_cnt_q + 8'd1;
          rdata_d = r_err_q ? '0 : ram_rdata_s;
          rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= 8'd0;
      r_cnt_q   <= 8'd0;
      r_id_q    <= '0;
      r_err_q   <= 1'b0;
      rdata_q   <= '0;
      rlast_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      arready_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_id_q    <= r_id_d;
      r_err_q   <= r_err_d;
      rdata_q   <= rdata_d;
      rlast_q   <= rlast_d;
      rvalid_q  <= rvalid_d;
      arready_q <= (r_state_d == R_IDLE);
    end
  end

  axi_full_s_ram #(
    .DATA_W (DW),
    .DEPTH  (C_S_MEM_DEPTH),
    .IW     (IW)
  ) u_ram (
    .clk_i   (S_AXI_ACLK),
    .we_i    (ram_we_s),
    .waddr_i (w_idx_q),
    .wdata_i (S_AXI_WDATA),
    .wstrb_i (S_AXI_WSTRB),
    .raddr_i (ram_raddr_s),
    .rdata_o (ram_rdata_s)
  );

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BID     = w_id_q;
  assign S_AXI_BRESP   = resp_of(w_err_q);
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RID     = r_id_q;
  assign S_AXI_RRESP   = resp_of(r_err_q);

endmodule

// File: tb/tb_axi_full_s_module.sv
// Directed self-checking bench for axi_full_s_module (default parameters).
module tb_axi_full_s_module;

  logic        clk = 1'b0;
  logic        areset;
  logic [0:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rlast, rvalid, rready;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rd_data [16];
  logic        rd_last [16];
  logic [1:0]  rd_resp [16];
  logic [0:0]  rd_id   [16];
  int          rd_n;
  logic [1:0]  last_bresp;
  logic [0:0]  last_bid;

  always #5 clk = ~clk;

  axi_full_s_module dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(areset),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] d0,
                          input logic [3:0] strb, input logic bad_wlast, input logic [0:0] id);
    int n;
    awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin tick(); n++; end
    if (n >= 50) check_eq("aw_timeout", 64'(n), 64'd0);
    tick();
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = d0 + 32'(i); wstrb = strb; wvalid = 1'b1;
      wlast = bad_wlast ? (i == 0) : (i == int'(len));
      n = 0;
      while (!wready && n < 50) begin tick(); n++; end
      if (n >= 50) check_eq("w_timeout", 64'(n), 64'd0);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    if (n >= 50) check_eq("b_timeout", 64'(n), 64'd0);
    last_bresp = bresp; last_bid = bid;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic toggle,
                         input logic [0:0] id);
    int n;
    int cyc;
    logic [31:0] hold_d;
    logic hold_v, hold_l, rr;
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    if (n >= 50) check_eq("ar_timeout", 64'(n), 64'd0);
    tick();
    arvalid = 1'b0;
    rd_n = 0; cyc = 0;
    while (rd_n <= int'(len) && cyc < 200) begin
      rready = toggle ? cyc[0] : 1'b1;
      rr = rready; hold_d = rdata; hold_v = rvalid; hold_l = rlast;
      if (rvalid && rready) begin
        rd_data[rd_n] = rdata; rd_last[rd_n] = rlast;
        rd_resp[rd_n] = rresp; rd_id[rd_n] = rid;
        rd_n++;
      end
      tick();
      if (hold_v && !rr) check_eq("stall_stable", {rvalid, rlast, rdata}, {1'b1, hold_l, hold_d});
      cyc++;
    end
    rready = 1'b0;
    if (rd_n <= int'(len)) check_eq("r_timeout", 64'(rd_n), 64'(len) + 64'd1);
  endtask

  initial begin
    areset = 1'b1;
    awid = 1'b0; awaddr = 32'd0; awlen = 8'd0; awvalid = 1'b0;
    wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = 1'b0; araddr = 32'd0; arlen = 8'd0; arvalid = 1'b0; rready = 1'b0;

    // Reset state and first cycle after release
    tick(); tick(); tick();
    check_eq("rst_awready", 64'(awready), 64'd0);
    check_eq("rst_arready", 64'(arready), 64'd0);
    check_eq("rst_vld", {bvalid, rvalid, wready, rlast}, 64'd0);
    areset = 1'b0;
    tick();
    check_eq("post_rst_awready", 64'(awready), 64'd1);
    check_eq("post_rst_arready", 64'(arready), 64'd1);

    // 4-beat write of 1..4 then read back
    do_write(32'h80000000, 8'd3, 32'd1, 4'hF, 1'b0, 1'b0);
    check_eq("s1_bresp", 64'(last_bresp), 64'd0);
    do_read(32'h80000000, 8'd3, 1'b0, 1'b0);
    check_eq("s1_beats", 64'(rd_n), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq("s1_rdata", 64'(rd_data[i]), 64'(i + 1));
      check_eq("s1_rlast", 64'(rd_last[i]), 64'(i == 3));
      check_eq("s1_rresp", 64'(rd_resp[i]), 64'd0);
    end

    // Byte-strobe merge
    do_write(32'h80000008, 8'd0, 32'hAABBCCDD, 4'hF, 1'b0, 1'b0);
    do_write(32'h80000008, 8'd0, 32'h11223344, 4'h3, 1'b0, 1'b0);
    do_read(32'h80000008, 8'd0, 1'b0, 1'b0);
    check_eq("s2_rdata", 64'(rd_data[0]), 64'hAABB3344);
    check_eq("s2_rlast", 64'(rd_last[0]), 64'd1);

    // 8-beat burst, WLAST asserted early (ignored), read with RREADY toggling
    do_write(32'h80000020, 8'd7, 32'h100, 4'hF, 1'b1, 1'b1);
    check_eq("s3_bresp", 64'(last_bresp), 64'd0);
    check_eq("s3_bid", 64'(last_bid), 64'd1);
    do_read(32'h80000020, 8'd7, 1'b1, 1'b1);
    check_eq("s3_beats", 64'(rd_n), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check_eq("s3_rdata", 64'(rd_data[i]), 64'h100 + 64'(i));
      check_eq("s3_rlast", 64'(rd_last[i]), 64'(i == 7));
      check_eq("s3_rid", 64'(rd_id[i]), 64'd1);
    end

    // Concurrent single-beat write (word 16) and read (word 0)
    awaddr = 32'h80000040; awlen = 8'd0; awid = 1'b0; awvalid = 1'b1;
    araddr = 32'h80000000; arlen = 8'd0; arid = 1'b0; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    check_eq("s4_rvalid_1cyc", 64'(rvalid), 64'd1);
    check_eq("s4_rdata", 64'(rdata), 64'd1);
    check_eq("s4_rlast", 64'(rlast), 64'd1);
    check_eq("s4_wready", 64'(wready), 64'd1);
    wdata = 32'h5A5A0001; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1; rready = 1'b1;
    tick();
    check_eq("s4_bvalid_1cyc", 64'(bvalid), 64'd1);
    check_eq("s4_rvalid_done", 64'(rvalid), 64'd0);
    check_eq("s4_arready_back", 64'(arready), 64'd1);
    wvalid = 1'b0; wlast = 1'b0; rready = 1'b0; bready = 1'b1;
    tick();
    bready = 1'b0;
    check_eq("s4_awready_back", 64'(awready), 64'd1);
    check_eq("s4_bvalid_done", 64'(bvalid), 64'd0);
    do_read(32'h80000040, 8'd0, 1'b0, 1'b0);
    check_eq("s4_word16", 64'(rd_data[0]), 64'h5A5A0001);

    // Reset in the middle of a 4-beat read
    araddr = 32'h80000000; arlen = 8'd3; arvalid = 1'b1;
    tick();
    arvalid = 1'b0; rready = 1'b1;
    tick();
    check_eq("s5_beat2_valid", 64'(rvalid), 64'd1);
    check_eq("s5_beat2_data", 64'(rdata), 64'd2);
    rready = 1'b0; areset = 1'b1;
    tick();
    check_eq("s5_rst_rvalid", 64'(rvalid), 64'd0);
    check_eq("s5_rst_arready", 64'(arready), 64'd0);
    check_eq("s5_rst_rlast", 64'(rlast), 64'd0);
    areset = 1'b0;
    tick();
    check_eq("s5_arready_after", 64'(arready), 64'd1);
    check_eq("s5_rvalid_after", 64'(rvalid), 64'd0);

    // Write just past the window (BASE + DEPTH*4)
    do_write(32'h80000400, 8'd0, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
`ifdef AXI_FULL_S_ERRRESP_EN
    check_eq("s6_bresp_slverr", 64'(last_bresp), 64'd2);
    do_read(32'h80000000, 8'd0, 1'b0, 1'b0);
    check_eq("s6_word0_kept", 64'(rd_data[0]), 64'd1);
    do_read(32'h80000400, 8'd0, 1'b0, 1'b0);
    check_eq("s6_rresp_slverr", 64'(rd_resp[0]), 64'd2);
    check_eq("s6_rdata_zero", 64'(rd_data[0]), 64'd0);
`else
    check_eq("s6_bresp_okay", 64'(last_bresp), 64'd0);
    do_read(32'h80000000, 8'd0, 1'b0, 1'b0);
    check_eq("s6_word0_wrapped", 64'(rd_data[0]), 64'hDEADBEEF);
    check_eq("s6_rresp_okay", 64'(rd_resp[0]), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_full_s_module.md
AXI_FULL_S_MODULE -- requirements
Module: axi_full_s_module

Interface
REQ-001 The module SHALL have parameter C_S_TARGET_SLAVE_BASE_ADDR, default 32'h80000000, meaning the byte address mapped to memory word 0.
REQ-002 The module SHALL have parameter C_S_AXI_ID_WIDTH, default 1, meaning the ID width on all channels.
REQ-003 The module SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, meaning the address width.
REQ-004 The module SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, meaning the data width (32 or 64).
REQ-005 The module SHALL have parameter C_S_MEM_DEPTH, default 256, meaning the number of data-width words (power of 2).
REQ-006 The module SHALL have the following ports, in this order:
- S_AXI_ACLK  in  1  the single clock; all logic on its rising edge.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWID  in  ID  write burst ID.
- S_AXI_AWADDR  in  ADDR  write start byte address.
- S_AXI_AWLEN  in  8  write beats minus 1.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake.
- S_AXI_WDATA  in  DATA  write data.
- S_AXI_WSTRB  in  DATA/8  byte enables.
- S_AXI_WLAST  in  1  final write beat.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake.
- S_AXI_BID  out  ID  echoed AWID.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake.
- S_AXI_ARID  in  ID  read burst ID.
- S_AXI_ARADDR  in  ADDR  read start byte address.
- S_AXI_ARLEN  in  8  read beats minus 1.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake.
- S_AXI_RID  out  ID  echoed ARID.
- S_AXI_RDATA  out  DATA  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RLAST  out  1  final read beat.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake.

Function
REQ-007 The module SHALL treat every burst as INCR with full-width beats; the word index SHALL be ((ADDR - BASE) >> log2(DATA/8)) modulo C_S_MEM_DEPTH and SHALL increment by 1 per beat, wrapping at C_S_MEM_DEPTH.
REQ-008 The write FSM SHALL use states W_IDLE (AWREADY=1) -> W_DATA on AW handshake (latch ID, index, LEN; WREADY=1) -> W_RESP on the W handshake carrying the beat count LEN+1 (BVALID=1) -> W_IDLE on B handshake.
REQ-009 Each W handshake SHALL update only the bytes whose WSTRB bit is 1, in the same cycle.
REQ-010 A WLAST that does not match the beat count SHALL be ignored; the beat count alone SHALL end the burst.
REQ-011 The read FSM SHALL use states R_IDLE (ARREADY=1) -> R_DATA on AR handshake -> R_IDLE after the handshake of the beat with RLAST=1.
REQ-012 The first RVALID SHALL assert 1 cycle after the AR handshake; with RREADY held high, one beat SHALL be delivered per cycle.
REQ-013 RDATA, RLAST and RID SHALL stay stable while RVALID=1 and RREADY=0.
REQ-014 RLAST SHALL be 1 only on beat ARLEN+1.
REQ-015 Read and write SHALL be independent and concurrent, with at most one outstanding burst per direction.
REQ-016 On a same-word write and read in the same cycle, the read SHALL return the old data.
REQ-017 BRESP and RRESP SHALL be 2'b00 (OKAY) unless REQ-021 applies.

Reset
REQ-018 While S_AXI_ARESET=1, both FSMs SHALL go to IDLE and AWREADY, WREADY, BVALID, ARREADY, RVALID and RLAST SHALL be 0, including when a burst is in progress (that burst is abandoned).
REQ-019 AWREADY and ARREADY SHALL be 1 in the first cycle after reset deassertion.
REQ-020 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-021 With AXI_FULL_S_ERRRESP_EN defined, a burst whose start or end address is outside BASE..BASE+DEPTH*DATA/8-1 SHALL complete all its handshakes, SHALL NOT write memory, SHALL return RDATA=0, and SHALL return SLVERR (2'b10) on BRESP or on every RRESP beat; without the macro, addresses wrap per REQ-007 and the response is always OKAY.

Structure
REQ-022 A package axi_full_pkg SHALL hold the FSM state encodings and the RESP constants (OKAY, SLVERR).
REQ-023 The storage SHALL be one sub-module, axi_full_s_ram: a dual-port array with a byte-enabled write port and a combinational read port.

Verification
REQ-024 The bench SHALL cover these scenarios:
- AWADDR=0x80000000, AWLEN=3, data 1..4, WSTRB=0xF; then ARLEN=3 at the same address -> RDATA 1,2,3,4, RLAST on beat 4, BRESP=OKAY.
- Write 0xAABBCCDD to 0x80000008, then 0x11223344 with WSTRB=0x3 -> read gives 0xAABB3344.
- Read with ARLEN=7 and RREADY toggled every other cycle -> 8 beats in order, RDATA stable during stalls.
- AWLEN=0 with ARLEN=0 issued concurrently to a different word -> BVALID 1 cycle after the W beat; RVALID 1 cycle after the AR handshake.
- Assert reset during beat 2 of a 4-beat read -> RVALID=0 next cycle; ARREADY=1 the cycle after reset drops.
- With AXI_FULL_S_ERRRESP_EN, write to BASE+DEPTH*4 -> BRESP=2'b10 and memory unchanged.
